// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble/flush controller for the rv32i 5-stage pipeline.
// Captures early memory responses during a freeze and keeps saturating event counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic [31:0]      imem_rdata,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [31:0]      dmem_rdata,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_bubble,
    output logic             exmem_stall,
    output logic             memwb_stall,
    output logic [31:0]      if_instr,
    output logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             i_wait;
    logic             d_wait;
    logic             freeze;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             load_use;

    logic             i_done_q, i_done_d;
    logic             d_done_q, d_done_d;
    logic [31:0]      ibuf_q, ibuf_d;
    logic [31:0]      dbuf_q, dbuf_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A side only waits until its response has been captured once in this freeze.
    always_comb begin
        i_wait   = imem_read & ~imem_resp & ~i_done_q;
        d_wait   = dmem_req & ~dmem_resp & ~d_done_q;
        freeze   = i_wait | d_wait;
        rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
        rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
        load_use = ex_is_load & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_bubble = 1'b0;
        exmem_stall = 1'b0;
        memwb_stall = 1'b0;
        if (freeze) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_stall = 1'b1;
        end else if (ex_redirect) begin
            // The ID instruction is squashed, so a pending load-use is moot.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        i_done_d       = i_done_q;
        d_done_d       = d_done_q;
        ibuf_d         = ibuf_q;
        dbuf_d         = dbuf_q;
        stall_cycles_d = stall_cycles_q;
        bubble_cnt_d   = bubble_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        if (freeze) begin
            if (imem_resp & imem_read) begin
                i_done_d = 1'b1;
                ibuf_d   = imem_rdata;
            end
            if (dmem_resp & dmem_req) begin
                d_done_d = 1'b1;
                dbuf_d   = dmem_rdata;
            end
            stall_cycles_d = sat_inc(stall_cycles_q);
        end else begin
            // Pipeline advances; any held response has just been consumed.
            i_done_d = 1'b0;
            d_done_d = 1'b0;
            if (ex_redirect) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end else if (load_use) begin
                bubble_cnt_d = sat_inc(bubble_cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_done_q       <= 1'b0;
            d_done_q       <= 1'b0;
            ibuf_q         <= 32'd0;
            dbuf_q         <= 32'd0;
            stall_cycles_q <= '0;
            bubble_cnt_q   <= '0;
            flush_cnt_q    <= '0;
        end else begin
            i_done_q       <= i_done_d;
            d_done_q       <= d_done_d;
            ibuf_q         <= ibuf_d;
            dbuf_q         <= dbuf_d;
            stall_cycles_q <= stall_cycles_d;
            bubble_cnt_q   <= bubble_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign if_instr     = i_done_q ? ibuf_q : imem_rdata;
    assign mem_rdata    = d_done_q ? dbuf_q : dmem_rdata;
    assign stall_cycles = stall_cycles_q;
    assign bubble_cnt   = bubble_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule
